bus_mux_pipe: RTL
=================

Name: bus_mux_pipe

Overview:
- Parametrised N:1 bus multiplexer with a registered, flow-controlled output stage.
- Replaces fixed 32-bit 2:1 select muxes wherever a selected operand crosses a pipeline boundary (forwarding select into EX, writeback source select).
- Adds a valid/ready handshake with a 2-entry skid buffer, so a downstream stall never creates a combinational path back to the producer.
- Also provides a synchronous flush and a sticky error flag for out-of-range selects.

Parameters:
- WIDTH, 32, bit width of each input bus and of the output.
- N_IN, 2, number of input buses; legal range 2..16.
- SEL_W, derived localparam = $clog2(N_IN), select width; not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_bus  in  N_IN*WIDTH  packed inputs; input k occupies bits [k*WIDTH +: WIDTH].
- sel  in  SEL_W  source index, sampled on an accepted beat.
- in_valid  in  1  producer offers a beat.
- in_ready  out  1  stage can accept a beat.
- out_data  out  WIDTH  registered selected data.
- out_valid  out  1  out_data holds a valid beat.
- out_ready  in  1  consumer accepts out_data.
- flush  in  1  synchronous discard of all held beats.
- sel_err  out  1  sticky flag: an accepted beat carried sel >= N_IN.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Reset values while rst_n = 0:
  - state = EMPTY; out_valid = 0; out_data = 0; skid register = 0; sel_err = 0.
  - in_ready = 1, decoded from state; in_valid is ignored during reset.
- Handshake definitions:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Data path:
  - On accept, the captured word is in_bus[sel].
  - If sel >= N_IN, the captured word is 0 and sel_err is set.
- Latency: 1 cycle. A beat accepted at edge t appears on out_data with out_valid = 1 after edge t.
- in_ready = (state != FULL). It is a pure decode of the state register; there is no combinational path from out_ready or in_valid.
- out_valid = (state != EMPTY).
- State machine (states EMPTY, ONE, FULL):
  - EMPTY: accept -> ONE, main <= new.
  - ONE, accept & !pop -> FULL, skid <= new.
  - ONE, accept & pop -> ONE, main <= new.
  - ONE, !accept & pop -> EMPTY.
  - ONE, !accept & !pop -> hold.
  - FULL: pop -> ONE, main <= skid; otherwise hold. No accept is possible in FULL.
- Ordering: beats leave strictly in acceptance order. No beat is duplicated or dropped except by flush.
- Throughput: with out_ready held at 1, one beat per cycle; the stage never enters FULL.
- flush has the highest priority:
  - Next state = EMPTY.
  - A coincident accept is discarded and a coincident pop is not counted.
  - sel_err is cleared.
  - Held data registers keep stale values; they are don't-care while out_valid = 0.
- Simultaneous sel_err set and flush: flush wins, sel_err = 0.
- out_data changes only when the main register loads. It is stable while out_valid & !out_ready.
- Reset asserted mid-transfer: all beats are lost and outputs take their reset values immediately, without waiting for a clock edge.

Decomposition:
- Shared package:
  - mux_state_t enum {EMPTY, ONE, FULL}, 2 bits.
  - Localparam MAX_N_IN = 16.
  - Helper function sel_width(n).
- Sub-module bus_mux_n:
  - Purely combinational N_IN:1 WIDTH-bit select.
  - Outputs 0 and asserts an out-of-range flag when sel >= N_IN.
  - Instantiated once, ahead of the capture registers.
- The skid/FSM logic stays in bus_mux_pipe.

Test Plan:
- Reset, WIDTH=32 N_IN=2: hold rst_n=0 -> out_valid=0, out_data=0, in_ready=1, sel_err=0. Release, then in_bus={32'hBBBB0002,32'hAAAA0001}, sel=1, in_valid=1 for 1 cycle -> next cycle out_valid=1, out_data=32'hBBBB0002.
- Streaming, N_IN=4, out_ready=1: 8 consecutive beats, sel cycling 0..3, input k=32'h1000+k -> outputs 1000,1001,1002,1003 repeating, one per cycle, in_ready never drops.
- Backpressure: out_ready=0 while 3 beats are offered -> first two accepted (state FULL), in_ready=0 on the third, out_data frozen on beat 1. Raise out_ready -> beats 1,2,3 emerge in order with no loss.
- Out of range, N_IN=3: accept sel=3 -> out_data=0, sel_err=1 and it stays 1 across later legal beats. Pulse flush -> sel_err=0, out_valid=0.
- Flush in FULL with in_valid=1: next cycle out_valid=0, in_ready=1; the coincident input never appears on the output.
- Async reset mid-burst, state FULL: drop rst_n between edges -> out_valid=0 and out_data=0 without waiting for clk. After release, a new beat flows with 1-cycle latency.

Source files
------------

// File: rtl/bus_mux_pipe_pkg.sv
// Shared types and helpers for the registered N:1 bus multiplexer.
// Imported by the interface, the select sub-module and the top.
package bus_mux_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } mux_state_t;

    localparam int MAX_N_IN = 16;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_mux_pipe_if.sv
// Producer/consumer bundle for bus_mux_pipe.
// master = the side driving beats in; slave = the mux stage itself.
interface bus_mux_pipe_if #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 2
);
    import bus_mux_pipe_pkg::*;

    localparam int SEL_W = sel_width(N_IN);

    logic [N_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]      sel;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  flush;
    logic                  sel_err;

    modport master (
        output in_bus,
        output sel,
        output in_valid,
        output out_ready,
        output flush,
        input  in_ready,
        input  out_data,
        input  out_valid,
        input  sel_err
    );

    modport slave (
        input  in_bus,
        input  sel,
        input  in_valid,
        input  out_ready,
        input  flush,
        output in_ready,
        output out_data,
        output out_valid,
        output sel_err
    );

endinterface

// File: rtl/bus_mux_pipe_mux.sv
// Combinational N_IN:1 select; out-of-range index yields zero
// and raises o_oor.
module bus_mux_n
    import bus_mux_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_IN  = 2
) (
    input  logic [N_IN*WIDTH-1:0]        i_bus,
    input  logic [sel_width(N_IN)-1:0]   i_sel,
    output logic [WIDTH-1:0]             o_data,
    output logic                         o_oor
);

    localparam int SEL_W = sel_width(N_IN);

    always_comb begin
        o_data = '0;
        o_oor  = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (i_sel == SEL_W'(k)) begin
                o_data = i_bus[k*WIDTH +: WIDTH];
                o_oor  = 1'b0;
            end
        end
    end

endmodule

// File: rtl/bus_mux_pipe.sv
// Registered N:1 bus mux with a 2-entry skid buffer, flush and a
// sticky out-of-range flag.
module bus_mux_pipe
    import bus_mux_pipe_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N_IN  = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    bus_mux_pipe_if.slave bus
);

    mux_state_t       r_state;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_err;

    logic [WIDTH-1:0] w_data;
    logic             w_oor;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_accept;
    logic             w_pop;

    bus_mux_n #(
        .WIDTH (WIDTH),
        .N_IN  (N_IN)
    ) u_mux (
        .i_bus  (bus.in_bus),
        .i_sel  (bus.sel),
        .o_data (w_data),
        .o_oor  (w_oor)
    );

    // Ready depends on state only, so a stall never reaches the producer
    assign w_in_ready  = (r_state != FULL);
    assign w_out_valid = (r_state != EMPTY);
    assign w_accept    = bus.in_valid & w_in_ready;
    assign w_pop       = w_out_valid & bus.out_ready;

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = r_main;
    assign bus.sel_err   = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_main  <= '0;
            r_skid  <= '0;
            r_err   <= 1'b0;
        end else if (bus.flush) begin
            r_state <= EMPTY;
            r_err   <= 1'b0;
        end else begin
            if (w_accept && w_oor) begin
                r_err <= 1'b1;
            end
            unique case (r_state)
                EMPTY: begin
                    if (w_accept) begin
                        r_state <= ONE;
                        r_main  <= w_data;
                    end
                end
                ONE: begin
                    if (w_accept && !w_pop) begin
                        r_state <= FULL;
                        r_skid  <= w_data;
                    end else if (w_accept) begin
                        r_main  <= w_data;
                    end else if (w_pop) begin
                        r_state <= EMPTY;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_state <= ONE;
                        r_main  <= r_skid;
                    end
                end
                default: r_state <= EMPTY;
            endcase
        end
    end

endmodule
